// File: rtl/alu_md_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: operation codes and FSM states.
package alu_md_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DONE     = 2'd2
  } state_e;

endpackage

// File: rtl/alu_md_if.sv
// Request/response bundle between a producer (master) and the ALU/MD unit (slave).
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            m_ext;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_data;

  modport master (
    output flush, in_valid, m_ext, alu_op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, alu_data
  );

  modport slave (
    input  flush, in_valid, m_ext, alu_op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, alu_data
  );
endinterface

// File: rtl/alu_md_div.sv
// Iterative restoring divider on operand magnitudes, one quotient bit per cycle.
// done_o marks the final step; quotient_o/remainder_o then carry the sign-corrected result.
module alu_md_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort_i,
  input  logic            start_i,
  input  logic            sgn_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            busy_q, busy_d, negq_q, negq_d, negr_q, negr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN:0]   trial;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? ('0 - v) : v;
  endfunction

  // Sign bit of the trial subtraction set means the shifted remainder is below the divisor.
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = mag(dividend_i, sgn_i);
      rem_d  = '0;
      dvs_d  = mag(divisor_i, sgn_i);
      negq_d = sgn_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      negr_d = sgn_i && dividend_i[XLEN-1];
    end else if (busy_q) begin
      quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
      rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == LAST) && !abort_i;
  assign quotient_o  = negq_q ? ('0 - quo_d) : quo_d;
  assign remainder_o = negr_q ? ('0 - rem_d) : rem_d;

endmodule

// File: rtl/alu_md.sv
// Single-issue integer ALU with multiply/divide extension; base and multiply ops finish in one
// cycle, regular divides run through the iterative divider.
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic     clk,
  input  logic     rst,
  alu_md_if.slave  bus
);
  import alu_md_pkg::*;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        alu_data_q, alu_data_d;
  logic                   rem_sel_q, rem_sel_d;
  logic                   accept, is_div, div_signed, div_zero, div_ovf, div_start;
  logic                   div_busy, div_done;
  logic [XLEN-1:0]        div_quo, div_rem, base_res, mul_res, fast_res;
  logic [SHW-1:0]         shamt;
  logic [2:0]             f3;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [2*XLEN-1:0]      mul_a, mul_b, mul_p;

  assign f3         = bus.alu_op[2:0];
  assign shamt      = bus.operand_b[SHW-1:0];
  assign a_s        = bus.operand_a;
  assign b_s        = bus.operand_b;
  assign accept     = bus.in_valid && bus.in_ready && !bus.flush;
  assign is_div     = bus.m_ext && f3[2];
  assign div_signed = !f3[0];
  assign div_zero   = (bus.operand_b == '0);
  assign div_ovf    = div_signed && (bus.operand_a == MOST_NEG) && (bus.operand_b == '1);
  // Divide-by-zero and signed overflow have fixed answers and skip the divider.
  assign div_start  = accept && is_div && !div_zero && !div_ovf;

  always_comb begin
    case (bus.alu_op)
      OP_ADD:  base_res = bus.operand_a + bus.operand_b;
      OP_SUB:  base_res = bus.operand_a - bus.operand_b;
      OP_SLL:  base_res = bus.operand_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, a_s < b_s};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, bus.operand_a < bus.operand_b};
      OP_XOR:  base_res = bus.operand_a ^ bus.operand_b;
      OP_SRL:  base_res = bus.operand_a >> shamt;
      OP_SRA:  base_res = a_s >>> shamt;
      OP_OR:   base_res = bus.operand_a | bus.operand_b;
      OP_AND:  base_res = bus.operand_a & bus.operand_b;
      default: base_res = bus.operand_b;
    endcase
  end

  // One 2*XLEN multiplier serves all four variants via per-operand sign extension.
  always_comb begin
    mul_a   = {{XLEN{bus.operand_a[XLEN-1] && (f3 == M_MULH || f3 == M_MULHSU)}}, bus.operand_a};
    mul_b   = {{XLEN{bus.operand_b[XLEN-1] && (f3 == M_MULH)}}, bus.operand_b};
    mul_p   = mul_a * mul_b;
    mul_res = (f3 == M_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
  end

  always_comb begin
    if (!bus.m_ext)    fast_res = base_res;
    else if (!f3[2])   fast_res = mul_res;
    else if (div_zero) fast_res = f3[1] ? bus.operand_a : '1;
    else               fast_res = f3[1] ? '0 : bus.operand_a;
  end

  always_comb begin
    state_d    = state_q;
    alu_data_d = alu_data_q;
    rem_sel_d  = rem_sel_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_sel_d = f3[1];
          if (div_start) begin
            state_d = DIV_BUSY;
          end else begin
            state_d    = DONE;
            alu_data_d = fast_res;
          end
        end
      end
      DIV_BUSY: begin
        if (div_done) begin
          state_d    = DONE;
          alu_data_d = rem_sel_q ? div_rem : div_quo;
        end
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_data_q <= '0;
      rem_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_data_q <= alu_data_d;
      rem_sel_q  <= rem_sel_d;
    end
  end

  alu_md_div #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .abort_i     (bus.flush),
    .start_i     (div_start),
    .sgn_i       (div_signed),
    .dividend_i  (bus.operand_a),
    .divisor_i   (bus.operand_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign bus.in_ready  = (state_q == IDLE) && !div_busy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_data  = alu_data_q;

endmodule

// File: tb/tb_alu_md.sv
// Randomized scoreboard bench for alu_md (XLEN=32) with directed corner cases,
// backpressure, flush and mid-divide reset scenarios.
module tb_alu_md;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_md_if #(.XLEN(XLEN)) bus();
  alu_md #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    int          id;
  } item_t;

  item_t       sb_q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          id_ctr = 0;
  bit          seen = 0;
  bit          rdy_bad = 0;
  bit          expect_idle = 0;
  bit          rand_rdy = 0;
  logic [31:0] held;
  logic [31:0] r_exp, r_a, r_b, cap;
  logic [3:0]  r_op;
  bit          r_m;
  int          r_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic on the architectural definitions.
  function automatic void model(input bit m, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output int lat);
    int          ia, ib;
    longint      p;
    logic [63:0] pu;
    ia  = a;
    ib  = b;
    lat = 1;
    r   = b;
    if (!m) begin
      case (op)
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0001: r = a << b[4:0];
        4'b0010: r = (ia < ib) ? 32'd1 : 32'd0;
        4'b0011: r = (a < b) ? 32'd1 : 32'd0;
        4'b0100: r = a ^ b;
        4'b0101: r = a >> b[4:0];
        4'b1101: r = ia >>> b[4:0];
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        default: r = b;
      endcase
    end else begin
      case (op[2:0])
        3'd0: begin p = longint'(ia) * longint'(ib); r = p[31:0]; end
        3'd1: begin p = longint'(ia) * longint'(ib); r = p[63:32]; end
        3'd2: begin p = longint'(ia) * longint'({32'b0, b}); r = p[63:32]; end
        3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
        3'd4: if (b == 0) r = 32'hFFFFFFFF;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
              else begin r = ia / ib; lat = 33; end
        3'd5: if (b == 0) r = 32'hFFFFFFFF; else begin r = a / b; lat = 33; end
        3'd6: if (b == 0) r = a;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
              else begin r = ia % ib; lat = 33; end
        default: if (b == 0) r = a; else begin r = a % b; lat = 33; end
      endcase
    end
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares each presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (expect_idle) begin
        chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
        expect_idle = 0;
      end
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            chk($sformatf("data#%0d", sb_q[0].id), bus.alu_data, sb_q[0].data);
            chk($sformatf("latency#%0d", sb_q[0].id), 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
            chk($sformatf("in_ready_low#%0d", sb_q[0].id), 32'(rdy_bad | bus.in_ready), 32'd0);
          end else begin
            chk("hold_stable", bus.alu_data, held);
          end
          held = bus.alu_data;
          if (bus.out_ready) begin
            void'(sb_q.pop_front());
            seen = 0;
            rdy_bad = 0;
            expect_idle = 1;
          end
        end
      end else if (sb_q.size() != 0 && bus.in_ready) begin
        rdy_bad = 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input bit m, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.m_ext     = m;
    bus.alu_op    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    id_ctr++;
    sb_q.push_back('{data: exp, lat: lat, acc: cyc - 1, id: id_ctr});
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #2; n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      seen = 0;
    end
    @(posedge clk); #2;
  endtask

  task automatic quiet(input string name, input int cycles);
    bit v = 0;
    repeat (cycles) begin
      @(posedge clk); #2;
      if (bus.out_valid) v = 1;
    end
    chk(name, 32'(v), 32'd0);
  endtask

  task automatic abandon();
    sb_q.delete();
    seen = 0;
    rdy_bad = 0;
    expect_idle = 0;
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.m_ext = 1'b0; bus.alu_op = 4'd0;
    bus.operand_a = '0; bus.operand_b = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_data", bus.alu_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    issue(0, 4'b0010, 32'h80000000, 32'h00000001, 32'h00000001, 1);
    issue(0, 4'b0011, 32'h80000000, 32'h00000001, 32'h00000000, 1);
    issue(0, 4'b1101, 32'h80000000, 32'h00000004, 32'hF8000000, 1);
    issue(1, 4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
    issue(1, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    issue(1, 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(1, 4'b0100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    issue(1, 4'b0110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    issue(1, 4'b0101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1);
    issue(1, 4'b0111, 32'h00000005, 32'h00000000, 32'h00000005, 1);
    issue(1, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    issue(1, 4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    issue(0, 4'b0000, 32'd3, 32'd4, 32'd7, 1);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    issue(0, 4'b0000, 32'd10, 32'd20, 32'd30, 1);
    cap = bus.alu_data;
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_alu_data", bus.alu_data, cap);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    drain();

    // Flush partway through a divide.
    issue(1, 4'b0100, 32'd100, 32'd7, 32'd14, 33);
    repeat (9) begin @(posedge clk); #2; end
    bus.flush = 1'b1;
    @(posedge clk); #2;
    bus.flush = 1'b0;
    abandon();
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    quiet("flush_no_out_valid", 40);

    // Asynchronous reset partway through a divide.
    issue(1, 4'b0100, 32'd100, 32'd7, 32'd14, 33);
    repeat (9) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    abandon();
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_alu_data", bus.alu_data, 32'd0);
    quiet("rst_no_out_valid", 40);
    issue(0, 4'b0000, 32'd3, 32'd4, 32'd7, 1);
    drain();

    rand_rdy = 1;
    repeat (150) begin
      r_m  = 1'($urandom_range(0, 1));
      r_op = 4'($urandom_range(0, 15));
      r_a  = rnd_opnd();
      r_b  = rnd_opnd();
      model(r_m, r_op, r_a, r_b, r_exp, r_lat);
      issue(r_m, r_op, r_a, r_b, r_exp, r_lat);
    end
    drain();
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 32 or 64.
REQ-002 Parameter SHW, default $clog2(XLEN): shift-amount bits taken from operand_b.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous abort of any accepted/in-flight operation.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 m_ext  input  1  0 = base ALU op, 1 = multiply/divide op.
REQ-009 alu_op  input  4  base op code when m_ext=0; [2:0] = M funct3 when m_ext=1.
REQ-010 operand_a, operand_b  input  XLEN  source operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 alu_data  output  XLEN  result, held stable while out_valid && !out_ready.

Function
REQ-014 Base codes (m_ext=0): 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU (unsigned), 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; all other codes return operand_b (LUI pass-through).
REQ-015 SLT/SLTU return zero-extended 1 when a<b under signed/unsigned compare, else 0; must be correct for all sign combinations and for a-b overflow.
REQ-016 Shifts use operand_b[SHW-1:0]; SRA replicates operand_a[XLEN-1].
REQ-017 M funct3: 000 MUL (low XLEN), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-018 FSM states IDLE, DIV_BUSY, DONE; in_ready = (state==IDLE).
REQ-019 Accept = in_valid && in_ready && !flush; operands and op are registered on accept.
REQ-020 Base ops and all MUL ops: IDLE -> DONE; out_valid asserted the cycle after accept (latency 1).
REQ-021 DIV family: IDLE -> DIV_BUSY; restoring division on magnitudes, one quotient bit per cycle, XLEN cycles; then DONE; out_valid asserted exactly XLEN+1 cycles after accept.
REQ-022 Signed divide: quotient negated when operand signs differ; remainder takes dividend's sign.
REQ-023 Divide by zero: quotient = all ones, remainder = dividend; bypasses DIV_BUSY, latency 1.
REQ-024 Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0; latency 1.
REQ-025 DONE -> IDLE when out_ready; no new request accepted in the same cycle (one request in flight max).
REQ-026 flush in any state: next state IDLE, out_valid 0 next cycle, result discarded; flush wins over accept and out_ready in the same cycle.
REQ-027 alu_data is a register; its value when out_valid=0 is don't-care for consumers but must not be X after reset.

Reset
REQ-028 On rst assertion, immediately: state IDLE, out_valid 0, alu_data 0, divider counter/quotient/remainder 0; in_ready 1 after release.
REQ-029 rst mid-division abandons the operation; no out_valid follows release.

Structure
REQ-030 Package alu_md_pkg holds the base-op and M-funct3 constant/enum definitions and the FSM state enum typedef.
REQ-031 Iterative divider is a sub-module alu_md_div (start, operands, signed flag, busy/done, quotient, remainder); multiplier stays inline.

Verification
REQ-032 XLEN=32: SLT a=0x80000000, b=0x00000001 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-033 MULH 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MULHSU same -> 0xFFFFFFFF; each out_valid 1 cycle after accept.
REQ-034 DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; out_valid exactly 33 cycles after accept, in_ready low throughout.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; both latency 1.
REQ-036 Backpressure: out_ready held low 5 cycles -> out_valid and alu_data stable, in_ready low; release -> IDLE next cycle.
REQ-037 Flush at cycle 10 of DIV, and rst at cycle 10 of a second DIV -> no out_valid, in_ready 1 next cycle, following ADD 3+4 returns 7.
